// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with credit-tracked occupancy.
// Optional burst lock is enabled by defining FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  input  logic                          fifo_full,
  output logic [LVL_W-1:0]              level,
  output logic [ID_W-1:0]               grant_id,
  output logic                          err_overflow
);

  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [ID_W-1:0]       gid_q, gid_d;
  logic                  err_q, err_d;

  logic [ID_W-1:0]       win_c;
  logic                  win_vld_c;
  logic [ID_W-1:0]       sel_c;
  logic                  sel_vld_c;
  logic                  has_credit_c;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  accept_c;
  logic                  read_c;
  int unsigned           win_idx;

`ifdef FIFO_ARB_LOCK_EN
  logic                  lock_q, lock_d;
  logic [ID_W-1:0]       lock_id_q, lock_id_d;
`else
  logic                  unused_last;
  assign unused_last = ^req_last;
`endif

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_c     = gid_q;
    win_vld_c = 1'b0;
    win_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      win_idx = 32'(gid_q) + k;
      if (win_idx >= NUM_REQ) begin
        win_idx = win_idx - NUM_REQ;
      end
      if (!win_vld_c && req_valid[ID_W'(win_idx)]) begin
        win_vld_c = 1'b1;
        win_c     = ID_W'(win_idx);
      end
    end
  end

  // A held lock overrides arbitration, even while the owner is idle.
  always_comb begin
    sel_c     = win_c;
    sel_vld_c = win_vld_c;
`ifdef FIFO_ARB_LOCK_EN
    if (lock_q) begin
      sel_c     = lock_id_q;
      sel_vld_c = 1'b1;
    end
`endif
  end

  assign has_credit_c = (level_q < LVL_W'(FIFO_DEPTH));

  always_comb begin
    ready_c = '0;
    if (rst && has_credit_c && sel_vld_c) begin
      ready_c[sel_c] = 1'b1;
    end
  end

  assign accept_c = |(req_valid & ready_c);
  assign read_c   = fifo_rd_en && !fifo_empty;

  // Output register, credit counter and sticky overflow flag.
  always_comb begin
    wr_en_d = accept_c;
    data_d  = data_q;
    gid_d   = gid_q;
    level_d = level_q;
    err_d   = err_q | (wr_en_q & fifo_full);
    if (accept_c) begin
      data_d = req_data[32'(sel_c) * DATA_WIDTH +: DATA_WIDTH];
      gid_d  = sel_c;
    end
    if (accept_c && !read_c && (level_q != LVL_W'(FIFO_DEPTH))) begin
      level_d = level_q + LVL_W'(1);
    end else if (read_c && !accept_c && (level_q != '0)) begin
      level_d = level_q - LVL_W'(1);
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  // Lock on a non-last beat; a last beat from the owner releases it.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept_c) begin
      lock_d    = !req_last[sel_c];
      lock_id_d = sel_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
      level_q <= '0;
      gid_q   <= ID_W'(NUM_REQ - 1);
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      level_q <= level_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = ready_c;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign level        = level_q;
  assign grant_id     = gid_q;
  assign err_overflow = err_q;

endmodule
